// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional macro UART_ARB_TIMEOUT_EN adds a tx_busy-rise timeout with an err pulse.
module uart_tx_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_W         = 8,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        transmit,
  output logic [DATA_W-1:0]           TxData,
  input  logic                        tx_busy,
  output logic                        active,
  output logic [ID_W-1:0]             active_id,
  output logic                        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr;

  logic                w_found;
  logic [ID_W-1:0]     w_sel_id;
  logic [ID_W-1:0]     w_scan_idx;
  logic [DATA_W-1:0]   w_sel_data;
  logic [NUM_REQ-1:0]  w_ack_onehot;
  logic [ID_W-1:0]     w_rr_next;

  // NOTE: every signal gets a default before the scan so no path leaves it unassigned (no latch).
  always_comb begin
    w_found    = 1'b0;
    w_sel_id   = '0;
    w_scan_idx = '0;
    // Scan from the farthest offset down so the last hit is the one nearest the pointer.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan_idx = ID_W'((int'(r_rr) + k) % NUM_REQ);
      if (req[w_scan_idx]) begin
        w_found  = 1'b1;
        w_sel_id = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_sel_data              = req_data[w_sel_id * DATA_W +: DATA_W];
    w_ack_onehot            = '0;
    w_ack_onehot[active_id] = 1'b1;
    w_rr_next = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // NOTE: all state and registered outputs update with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      ack       <= '0;
      transmit  <= 1'b0;
      TxData    <= '0;
      active    <= 1'b0;
      active_id <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!tx_busy && w_found) begin
            active_id <= w_sel_id;
            TxData    <= w_sel_data;
            transmit  <= 1'b1;
            active    <= 1'b1;
            r_state   <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          transmit <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state  <= tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Transmitter never started: close the grant so the bus is not lost.
            ack     <= w_ack_onehot;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`else
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
`endif
        end

        S_WAIT_DONE: begin
          if (!tx_busy) begin
            ack     <= w_ack_onehot;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          ack     <= '0;
          active  <= 1'b0;
          r_rr    <= w_rr_next;
`ifdef UART_ARB_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
